speed_bar_array: RTL and testbench

//  Parametrised N-bar speed gauge overlay for the HDMI pixel path. Takes the

---
 rtl/speed_bar_array.sv | 222 ++++++++++++++++++++++
 tb/tb_speed_bar_array.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/speed_bar_array.sv
//==============================================================================
// Module      : speed_bar_array
// Description : N-bar speed gauge overlay for the HDMI pixel path. Returns a
//               4-bit intensity per pixel for a staggered row of bars. The
//               lit-bar count ramps one bar per RAMP_FRAMES animate pulses
//               toward a loadable target, and the top bar blinks at full
//               scale. Pixel path latency is a fixed 2 clocks.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module speed_bar_array #(
  parameter int N_BARS       = 8,
  parameter int COORD_W      = 12,
  parameter int PIX_W        = 4,
  parameter int X0           = 485,
  parameter int Y0           = 349,
  parameter int PITCH        = 15,
  parameter int Y_STEP       = 1,
  parameter int BAR_W        = 16,
  parameter int BAR_H        = 74,
  parameter int ON_LVL       = 15,
  parameter int DIM_LVL      = 3,
  parameter int RAMP_FRAMES  = 4,
  parameter int BLINK_FRAMES = 16,
  localparam int LW          = $clog2(N_BARS + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_animate,
  input  logic [LW-1:0]      i_level,
  input  logic               i_level_vld,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_de,
  output logic [PIX_W-1:0]   o_pix,
  output logic               o_de,
  output logic [LW-1:0]      o_level,
  output logic               o_busy
);

  // Counter widths; a period of 1 still needs a 1-bit counter.
  localparam int FW = (RAMP_FRAMES  > 1) ? $clog2(RAMP_FRAMES)  : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [FW-1:0]    RAMP_LAST  = FW'(RAMP_FRAMES - 1);
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [LW-1:0]    FULL       = LW'(N_BARS);
  localparam logic [PIX_W-1:0] ON_PIX     = PIX_W'(ON_LVL);
  localparam logic [PIX_W-1:0] DIM_PIX    = PIX_W'(DIM_LVL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [LW-1:0]   target;
  logic [LW-1:0]   level, level_n;
  logic [FW-1:0]   frame_cnt, frame_n;
  logic            busy;
  logic [BW-1:0]   blink_cnt, blink_cnt_n;
  logic            blink_ph, blink_ph_n;

  logic [COORD_W:0] x_ext, y_ext;
  logic [N_BARS-1:0] hit_d, hit_q, lit;
  logic              de_q;
  logic [PIX_W-1:0]  pix_n;

  //--------------------------------------------------------------------------
  // Level controller
  //--------------------------------------------------------------------------

  // Target register: any load is accepted, out-of-range values clamp to full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      target <= '0;
    end else if (i_level_vld) begin
      target <= (i_level > FULL) ? FULL : i_level;
    end
  end

  // Next-state / step logic: direction follows target vs level every cycle,
  // and a load in the same cycle as an animate pulse suppresses the step.
  always_comb begin
    state_n = state;
    level_n = level;
    frame_n = frame_cnt;

    if (target > level) begin
      state_n = UP;
    end else if (target < level) begin
      state_n = DOWN;
    end else begin
      state_n = IDLE;
    end

    if (i_level_vld) begin
      frame_n = '0;
    end else if (i_animate && (state != IDLE) && (target != level)) begin
      if (frame_cnt == RAMP_LAST) begin
        frame_n = '0;
        level_n = (target > level) ? (level + LW'(1)) : (level - LW'(1));
      end else begin
        frame_n = frame_cnt + FW'(1);
      end
    end
  end

  // State, displayed level, ramp counter and registered busy flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      level     <= '0;
      frame_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      level     <= level_n;
      frame_cnt <= frame_n;
      busy      <= (state_n != IDLE);
    end
  end

  //--------------------------------------------------------------------------
  // Blink phase: only runs while the gauge is pegged at full scale
  //--------------------------------------------------------------------------

  // Blink counter next value; held at zero whenever below full scale.
  always_comb begin
    blink_cnt_n = blink_cnt;
    blink_ph_n  = blink_ph;
    if (level != FULL) begin
      blink_cnt_n = '0;
      blink_ph_n  = 1'b0;
    end else if (i_animate) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_n = '0;
        blink_ph_n  = ~blink_ph;
      end else begin
        blink_cnt_n = blink_cnt + BW'(1);
      end
    end
  end

  // Blink registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_n;
      blink_ph  <= blink_ph_n;
    end
  end

  //--------------------------------------------------------------------------
  // Pixel path
  //--------------------------------------------------------------------------

  // One extra bit so the far bar edges never wrap at the coordinate limit.
  assign x_ext = {1'b0, i_x};
  assign y_ext = {1'b0, i_y};

  generate
    for (genvar k = 0; k < N_BARS; k++) begin : g_bar
      localparam int XL = X0 + k * PITCH;
      localparam int YL = Y0 + k * Y_STEP;
      localparam logic [COORD_W:0] X_LO = (COORD_W + 1)'(XL);
      localparam logic [COORD_W:0] X_HI = (COORD_W + 1)'(XL + BAR_W - 1);
      localparam logic [COORD_W:0] Y_LO = (COORD_W + 1)'(YL);
      localparam logic [COORD_W:0] Y_HI = (COORD_W + 1)'(YL + BAR_H - 1);
      localparam bit               TOP  = (k == N_BARS - 1);

      assign hit_d[k] = i_de &&
                        (x_ext >= X_LO) && (x_ext <= X_HI) &&
                        (y_ext >= Y_LO) && (y_ext <= Y_HI);

      // Top bar drops to dim during the off half of the full-scale blink.
      assign lit[k] = (level > LW'(k)) && !(TOP && blink_ph && (level == FULL));
    end
  endgenerate

  // Stage 1: register the per-bar hit vector alongside data enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_q <= '0;
      de_q  <= 1'b0;
    end else begin
      hit_q <= hit_d;
      de_q  <= i_de;
    end
  end

  // Priority resolve: the highest-numbered covering bar decides the pixel.
  always_comb begin
    pix_n = '0;
    for (int j = 0; j < N_BARS; j++) begin
      if (hit_q[j]) begin
        pix_n = lit[j] ? ON_PIX : DIM_PIX;
      end
    end
  end

  // Stage 2: register the resolved intensity and the delayed enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pix <= '0;
      o_de  <= 1'b0;
    end else begin
      o_pix <= de_q ? pix_n : '0;
      o_de  <= de_q;
    end
  end

  assign o_level = level;
  assign o_busy  = busy;

endmodule

`default_nettype wire

// File: tb/tb_speed_bar_array.sv
//==============================================================================
// Module      : tb_speed_bar_array
// Description : Directed self-checking bench for speed_bar_array with the
//               default parameter set (8 bars, 4 pulses/step, 16 pulses/blink).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_speed_bar_array;

  logic        clk;
  logic        rst_n;
  logic        animate;
  logic [3:0]  level_in;
  logic        level_vld;
  logic [11:0] x;
  logic [11:0] y;
  logic        de;
  logic [3:0]  pix;
  logic        de_out;
  logic [3:0]  level_out;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;

  speed_bar_array dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_animate   (animate),
    .i_level     (level_in),
    .i_level_vld (level_vld),
    .i_x         (x),
    .i_y         (y),
    .i_de        (de),
    .o_pix       (pix),
    .o_de        (de_out),
    .o_level     (level_out),
    .o_busy      (busy)
  );

  // 100 MHz pixel clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Load a target, then let the FSM settle into its direction.
  task automatic load(input logic [3:0] lvl);
    level_in  = lvl;
    level_vld = 1'b1;
    tick();
    level_vld = 1'b0;
    tick(2);
  endtask

  // n animate pulses, three clocks apart.
  task automatic pulse(input int n);
    repeat (n) begin
      animate = 1'b1;
      tick();
      animate = 1'b0;
      tick(2);
    end
  endtask

  // Present one pixel, check it is not visible after 1 clock, then check
  // value and enable after 2 clocks.
  task automatic probe(input string tag, input int px, input int py,
                       input logic pde, input int exp);
    x  = px[11:0];
    y  = py[11:0];
    de = pde;
    tick();
    de = 1'b0;
    check({tag, "_early_pix"}, 32'(pix), 32'd0);
    check({tag, "_early_de"}, 32'(de_out), 32'd0);
    tick();
    check({tag, "_pix"}, 32'(pix), 32'(exp));
    check({tag, "_de"}, 32'(de_out), 32'(pde));
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    animate   = 1'b0;
    level_in  = '0;
    level_vld = 1'b0;
    x         = '0;
    y         = '0;
    de        = 1'b0;
    tick(3);

    // Reset state
    check("rst_level", 32'(level_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pix", 32'(pix), 32'd0);
    check("rst_de", 32'(de_out), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Ramp 0 -> 5 over 20 pulses
    load(4'd5);
    check("t1_busy_start", 32'(busy), 32'd1);
    check("t1_level_start", 32'(level_out), 32'd0);
    pulse(19);
    check("t1_level_19", 32'(level_out), 32'd4);
    pulse(1);
    check("t1_level_20", 32'(level_out), 32'd5);
    check("t1_busy_end", 32'(busy), 32'd0);

    // Ramp down to 3, then raster sweep
    load(4'd3);
    pulse(4);
    check("t2_level_4", 32'(level_out), 32'd4);
    pulse(4);
    check("t2_level_3", 32'(level_out), 32'd3);
    check("t2_busy", 32'(busy), 32'd0);
    probe("bar0_corner", 485, 349, 1'b1, 15);
    probe("bar3_dim", 530, 352, 1'b1, 3);
    probe("left_of_bar0", 484, 349, 1'b1, 0);
    probe("bar2_lit", 520, 351, 1'b1, 15);
    probe("above_bar2", 520, 350, 1'b1, 0);
    probe("bar7_far", 605, 429, 1'b1, 3);
    probe("right_of_bar7", 606, 429, 1'b1, 0);
    probe("below_bar7", 605, 430, 1'b1, 0);
    probe("de_low", 485, 349, 1'b0, 0);

    // Retarget mid-ramp: 3 -> toward 8, at 4 retarget to 2
    load(4'd8);
    pulse(4);
    check("t3_level_4", 32'(level_out), 32'd4);
    load(4'd2);
    pulse(3);
    check("t3_hold_4", 32'(level_out), 32'd4);
    pulse(1);
    check("t3_level_3", 32'(level_out), 32'd3);
    pulse(4);
    check("t3_level_2", 32'(level_out), 32'd2);
    check("t3_busy", 32'(busy), 32'd0);
    pulse(4);
    check("t3_no_overshoot", 32'(level_out), 32'd2);

    // Load and animate together: load wins, ramp counter restarts
    load(4'd7);
    pulse(2);
    level_in  = 4'd7;
    level_vld = 1'b1;
    animate   = 1'b1;
    tick();
    level_vld = 1'b0;
    animate   = 1'b0;
    tick(2);
    check("t5_no_step", 32'(level_out), 32'd2);
    pulse(3);
    check("t5_hold_after3", 32'(level_out), 32'd2);
    pulse(1);
    check("t5_step_after4", 32'(level_out), 32'd3);

    // Clamp 15 -> 8 and top-bar blink
    load(4'd15);
    check("t4_busy", 32'(busy), 32'd1);
    pulse(19);
    check("t4_level_7", 32'(level_out), 32'd7);
    pulse(1);
    check("t4_level_8", 32'(level_out), 32'd8);
    check("t4_busy_end", 32'(busy), 32'd0);
    probe("blink_on0", 590, 356, 1'b1, 15);
    pulse(15);
    probe("blink_on15", 590, 356, 1'b1, 15);
    pulse(1);
    probe("blink_off", 590, 356, 1'b1, 3);
    probe("bar6_steady", 575, 355, 1'b1, 15);
    pulse(16);
    probe("blink_on_again", 590, 356, 1'b1, 15);
    check("t4_clamped", 32'(level_out), 32'd8);

    // Asynchronous reset mid-ramp and mid-line
    load(4'd6);
    pulse(2);
    x  = 12'd485;
    y  = 12'd349;
    de = 1'b1;
    tick(2);
    check("t6_pre_pix", 32'(pix), 32'd15);
    check("t6_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_pix", 32'(pix), 32'd0);
    check("t6_rst_de", 32'(de_out), 32'd0);
    check("t6_rst_level", 32'(level_out), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    tick();
    de    = 1'b0;
    rst_n = 1'b1;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
